// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Shares one cacheline memory port between the I-cache and D-cache
//            miss paths, one outstanding line transaction at a time.
// Revision : 1.0  initial release
// ============================================================================
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy
);

    localparam int                c_off_w     = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] c_addr_mask = {{(ADDR_W - c_off_w){1'b1}}, {c_off_w{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_BUSY = 2'd1,
        S_D_BUSY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic              last_d_q,    last_d_d;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [LINE_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_write_q, req_write_d;

    logic w_i_pend;
    logic w_d_pend;
    logic w_cmd_active;

    assign w_i_pend = icache_read;
    assign w_d_pend = dcache_read | dcache_write;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_write_d = req_write_q;

        case (state_q)
            S_IDLE: begin
                // On a tie the I-cache wins only if the D-cache had the last grant.
                if (w_i_pend && (!w_d_pend || last_d_q)) begin
                    state_d     = S_I_BUSY;
                    last_d_d    = 1'b0;
                    req_addr_d  = icache_address;
                    req_wdata_d = '0;
                    req_write_d = 1'b0;
                end else if (w_d_pend) begin
                    state_d     = S_D_BUSY;
                    last_d_d    = 1'b1;
                    req_addr_d  = dcache_address;
                    req_wdata_d = dcache_wdata;
                    req_write_d = dcache_write;
                end
            end
            S_I_BUSY, S_D_BUSY: begin
                if (pmem_resp) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b1;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_write_q <= req_write_d;
        end
    end

    // Memory-side outputs decode from registered state only.
    assign w_cmd_active = (state_q == S_I_BUSY) || (state_q == S_D_BUSY);

    assign pmem_read    = w_cmd_active & ~req_write_q;
    assign pmem_write   = w_cmd_active &  req_write_q;
    assign pmem_address = w_cmd_active ? (req_addr_q & c_addr_mask) : '0;
    assign pmem_wdata   = w_cmd_active ? req_wdata_q : '0;

    // A reset in the completion cycle aborts the transaction, so no resp escapes.
    assign icache_resp  = (state_q == S_I_BUSY) & pmem_resp & ~rst;
    assign dcache_resp  = (state_q == S_D_BUSY) & pmem_resp & ~rst;

    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench for cache_arbiter: directed scenarios plus
//            randomized traffic compared against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int LINE_B = LINE_W / 8;

    typedef logic [LINE_W-1:0] line_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    line_t             icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    line_t             dcache_wdata;
    line_t             dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    line_t             pmem_wdata;
    line_t             pmem_rdata = '0;
    logic              pmem_resp  = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .busy           (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input line_t act, input line_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic line_t rand_line();
        line_t v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: answers a command after a latency, optionally
    // injects stray resp pulses while no command is pending.
    // ------------------------------------------------------------------
    int    mem_lat       = 5;
    bit    mem_rand_lat  = 1'b0;
    bit    mem_rand_data = 1'b0;
    bit    spurious_en   = 1'b0;
    line_t mem_data      = '0;
    bit    mem_busy      = 1'b0;
    int    mem_cnt       = 0;

    always @(posedge clk) begin
        #2;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (rst === 1'b1) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_rand_data ? rand_line() : mem_data;
                mem_busy   = 1'b0;
            end
        end else if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_rand_lat ? $urandom_range(1, 6) : mem_lat;
        end else if (spurious_en && $urandom_range(0, 9) == 0) begin
            pmem_resp = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one optional in-flight transaction plus a one-cycle
    // cool-down after each completion; checked every cycle at negedge.
    // ------------------------------------------------------------------
    bit                chk_en   = 1'b0;
    bit                m_active = 1'b0;
    bit                m_is_d   = 1'b0;
    bit                m_write  = 1'b0;
    bit                m_cool   = 1'b0;
    bit                m_last_d = 1'b1;
    logic [ADDR_W-1:0] m_addr   = '0;
    line_t             m_wdata  = '0;

    int                i_resp_cnt  = 0;
    int                d_resp_cnt  = 0;
    int                rd_cycles   = 0;
    int                overlap_cnt = 0;
    bit                prev_cmd    = 1'b0;
    bit                prev_resp   = 1'b0;
    bit                resp_log[$];
    logic [ADDR_W-1:0] grant_log[$];

    always @(negedge clk) begin
        bit exp_ir, exp_dr, i_p, d_p, cmd_now;
        if (chk_en) begin
            exp_ir = m_active && !m_is_d && (pmem_resp === 1'b1) && (rst !== 1'b1);
            exp_dr = m_active &&  m_is_d && (pmem_resp === 1'b1) && (rst !== 1'b1);
            chk("busy",         busy,         m_active || m_cool);
            chk("pmem_read",    pmem_read,    m_active && !m_write);
            chk("pmem_write",   pmem_write,   m_active && m_write);
            if (m_active) begin
                chk("pmem_address", pmem_address, m_addr - (m_addr % LINE_B));
                chk("pmem_wdata",   pmem_wdata,   m_wdata);
            end
            chk("icache_resp",  icache_resp,  exp_ir);
            chk("dcache_resp",  dcache_resp,  exp_dr);
            chk("icache_rdata", icache_rdata, pmem_rdata);
            chk("dcache_rdata", dcache_rdata, pmem_rdata);

            if (rst === 1'b1) begin
                m_active = 1'b0;
                m_cool   = 1'b0;
                m_last_d = 1'b1;
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_active) begin
                if (pmem_resp === 1'b1) begin
                    m_active = 1'b0;
                    m_cool   = 1'b1;
                end
            end else begin
                i_p = (icache_read === 1'b1);
                d_p = (dcache_read === 1'b1) || (dcache_write === 1'b1);
                if (i_p && (!d_p || m_last_d)) begin
                    m_active = 1'b1; m_is_d = 1'b0; m_write = 1'b0;
                    m_addr   = icache_address; m_wdata = '0; m_last_d = 1'b0;
                end else if (d_p) begin
                    m_active = 1'b1; m_is_d = 1'b1; m_write = (dcache_write === 1'b1);
                    m_addr   = dcache_address; m_wdata = dcache_wdata; m_last_d = 1'b1;
                end
            end
        end

        cmd_now = (pmem_read === 1'b1) || (pmem_write === 1'b1);
        if (icache_resp === 1'b1) begin i_resp_cnt++; resp_log.push_back(1'b0); end
        if (dcache_resp === 1'b1) begin d_resp_cnt++; resp_log.push_back(1'b1); end
        if (cmd_now && !prev_cmd) grant_log.push_back(pmem_address);
        if (prev_resp && cmd_now) overlap_cnt++;
        if (pmem_read === 1'b1) rd_cycles++;
        prev_cmd  = cmd_now;
        prev_resp = (icache_resp === 1'b1) || (dcache_resp === 1'b1);
    end

    // Waits for the chosen resp, then drops that cache's request at the next edge.
    task automatic await_resp(input bit is_d, input int bound, output bit got, output line_t data);
        got  = 1'b0;
        data = '0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk);
            if ((is_d ? dcache_resp : icache_resp) === 1'b1) begin
                got  = 1'b1;
                data = is_d ? dcache_rdata : icache_rdata;
            end
        end
        @(posedge clk); #1;
        if (is_d) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end else begin
            icache_read = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit    gi, gd;
        line_t di, dd, orig;
        int    i0, d0, rd0, g0, r0, tmo, il, dl, found;

        rst = 1'b1;
        icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;

        // Reset then idle
        @(posedge clk); #1; chk_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_cmds", {pmem_read, pmem_write, icache_resp, dcache_resp}, 4'b0);
        end
        chk("idle_addr",  pmem_address, '0);
        chk("idle_wdata", pmem_wdata,   '0);

        // Single I read
        mem_lat  = 5;
        mem_data = {LINE_B{8'hA5}};
        @(posedge clk); #1;
        icache_read = 1'b1; icache_address = 32'h0000_1234;
        i0 = i_resp_cnt; d0 = d_resp_cnt;
        @(negedge clk);
        chk("i_no_cmd_same_cycle", pmem_read, 1'b0);
        @(negedge clk);
        chk("i_cmd_read", pmem_read, 1'b1);
        chk("i_cmd_addr", pmem_address, 32'h0000_1220);
        await_resp(1'b0, 30, gi, di);
        chk("i_resp_seen", gi, 1'b1);
        chk("i_rdata", di, {LINE_B{8'hA5}});
        repeat (3) @(negedge clk);
        chk("i_resp_once", i_resp_cnt - i0, 1);
        chk("i_no_dresp",  d_resp_cnt - d0, 0);

        // D write-back with wdata changing mid-transaction
        orig = {(LINE_W / 32){32'h0123_4567}};
        @(posedge clk); #1;
        dcache_write = 1'b1; dcache_address = 32'h8000_0040; dcache_wdata = orig;
        rd0 = rd_cycles; d0 = d_resp_cnt;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        dcache_wdata = ~orig;
        @(negedge clk);
        chk("dw_write",      pmem_write,   1'b1);
        chk("dw_addr",       pmem_address, 32'h8000_0040);
        chk("dw_wdata_held", pmem_wdata,   orig);
        await_resp(1'b1, 30, gd, dd);
        chk("dw_resp_seen", gd, 1'b1);
        repeat (3) @(negedge clk);
        chk("dw_resp_once",  d_resp_cnt - d0, 1);
        chk("dw_no_read",    rd_cycles - rd0, 0);

        // Simultaneous requests right after reset, then a second tie
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        mem_lat = 3; mem_rand_data = 1'b1;
        g0 = grant_log.size();
        icache_read = 1'b1; icache_address = 32'h0000_0100;
        dcache_read = 1'b1; dcache_address = 32'h0000_0200;
        fork
            await_resp(1'b0, 40, gi, di);
            await_resp(1'b1, 40, gd, dd);
        join
        chk("tie1_i_seen", gi, 1'b1);
        chk("tie1_d_seen", gd, 1'b1);
        icache_read = 1'b1; icache_address = 32'h0000_0300;
        dcache_read = 1'b1; dcache_address = 32'h0000_0400;
        fork
            await_resp(1'b0, 40, gi, di);
            await_resp(1'b1, 40, gd, dd);
        join
        chk("tie_grant_count", grant_log.size() - g0, 4);
        chk("tie_grant0", grant_log[g0],     32'h0000_0100);
        chk("tie_grant1", grant_log[g0 + 1], 32'h0000_0200);
        chk("tie_grant2", grant_log[g0 + 2], 32'h0000_0300);
        chk("tie_grant3", grant_log[g0 + 3], 32'h0000_0400);

        // Continuous contention: both re-request right after each resp
        r0 = resp_log.size(); tmo = 0; overlap_cnt = 0;
        fork
            begin
                bit    g;
                line_t d;
                for (int k = 0; k < 4; k++) begin
                    icache_read = 1'b1; icache_address = 32'h0000_1000 + k * 64;
                    await_resp(1'b0, 60, g, d);
                    if (!g) tmo++;
                end
            end
            begin
                bit    g;
                line_t d;
                for (int k = 0; k < 4; k++) begin
                    dcache_read = 1'b1; dcache_address = 32'h0000_2000 + k * 64;
                    await_resp(1'b1, 60, g, d);
                    if (!g) tmo++;
                end
            end
        join
        chk("cont_timeouts", tmo, 0);
        chk("cont_count", resp_log.size() - r0, 8);
        for (int k = 0; k < 8; k++) chk("cont_alternate", resp_log[r0 + k], k % 2);
        chk("cont_no_overlap", overlap_cnt, 0);

        // Reset while in D_BUSY, two cycles before the response
        mem_lat = 6; d0 = d_resp_cnt; found = 0;
        @(posedge clk); #1;
        dcache_read = 1'b1; dcache_address = 32'h0000_3000;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (pmem_read === 1'b1) found = 1;
        end
        chk("rm_cmd_seen", found, 1);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1; dcache_read = 1'b0;
        @(negedge clk);
        chk("rm_cmd_until_edge", pmem_read, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rm_read_dropped", pmem_read, 1'b0);
        chk("rm_idle", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("rm_no_dresp", d_resp_cnt - d0, 0);

        // Randomized traffic with stray resps and occasional resets
        mem_rand_lat = 1'b1; mem_rand_data = 1'b1; spurious_en = 1'b1;
        il = i_resp_cnt; dl = d_resp_cnt;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int cmd;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) == 0);
            if (icache_read && i_resp_cnt != il) icache_read = 1'b0;
            if (!icache_read) begin
                if ($urandom_range(0, 2) == 0) begin
                    icache_read = 1'b1; icache_address = $urandom;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                icache_address = $urandom;
            end
            if ((dcache_read || dcache_write) && d_resp_cnt != dl) begin
                dcache_read = 1'b0; dcache_write = 1'b0;
            end
            if (!(dcache_read || dcache_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    cmd = $urandom_range(1, 3);
                    dcache_read    = cmd[0];
                    dcache_write   = cmd[1];
                    dcache_address = $urandom;
                    dcache_wdata   = rand_line();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dcache_wdata   = rand_line();
                dcache_address = $urandom;
            end
            il = i_resp_cnt; dl = d_resp_cnt;
        end

        @(posedge clk); #1;
        rst = 1'b0; icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
